// File: rtl/button_conditioner.sv
// Three-channel push-button conditioner: 2-flop synchronizer, debounce FSM,
// and one-cycle press / long-press pulses for each channel independently.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int DEBOUNCE_TICKS   = 3,
    parameter int LONG_PRESS_TICKS = 200
) (
    input  logic       clockSignal,
    input  logic       resetSignal,
    input  logic [2:0] buttonRaw,
    output logic [2:0] buttonLevel,
    output logic [2:0] pressPulse,
    output logic [2:0] longPulse
);
    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        LONG_DONE,
        RELEASE_WAIT
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic              r_sync1;
            logic              r_sync2;
            state_t            r_state;
            logic [DEB_W-1:0]  r_deb;
            logic [HOLD_W-1:0] r_hold;
            logic              r_fired;
            logic              r_level;
            logic              r_press;
            logic              r_long;
            logic [HOLD_W-1:0] w_hold_inc;

            // Hold time keeps counting through a release dropout so the long
            // pulse stays anchored to the original press.
            assign w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;

            always_ff @(posedge clockSignal or posedge resetSignal) begin
                if (resetSignal) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_state <= IDLE;
                    r_deb   <= '0;
                    r_hold  <= '0;
                    r_fired <= 1'b0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                    r_long  <= 1'b0;
                end else begin
                    r_sync1 <= buttonRaw[gi];
                    r_sync2 <= r_sync1;
                    r_press <= 1'b0;
                    r_long  <= 1'b0;
                    case (r_state)
                        IDLE: begin
                            if (r_sync2) begin
                                r_state <= PRESS_WAIT;
                                r_deb   <= DEB_ONE;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!r_sync2) begin
                                r_state <= IDLE;
                                r_deb   <= '0;
                            end else if (r_deb >= DEB_LAST) begin
                                r_state <= HELD;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                                r_hold  <= '0;
                                r_deb   <= '0;
                            end else begin
                                r_deb <= r_deb + 1'b1;
                            end
                        end
                        HELD: begin
                            r_hold <= w_hold_inc;
                            if (!r_sync2) begin
                                r_state <= RELEASE_WAIT;
                                r_deb   <= DEB_ONE;
                            end else if (r_hold >= HOLD_FIRE) begin
                                r_state <= LONG_DONE;
                                r_long  <= 1'b1;
                                r_fired <= 1'b1;
                            end
                        end
                        LONG_DONE: begin
                            r_hold <= w_hold_inc;
                            if (!r_sync2) begin
                                r_state <= RELEASE_WAIT;
                                r_deb   <= DEB_ONE;
                            end
                        end
                        RELEASE_WAIT: begin
                            r_hold <= w_hold_inc;
                            if (r_sync2) begin
                                r_state <= r_fired ? LONG_DONE : HELD;
                                r_deb   <= '0;
                            end else if (r_deb >= DEB_LAST) begin
                                r_state <= IDLE;
                                r_level <= 1'b0;
                                r_hold  <= '0;
                                r_fired <= 1'b0;
                                r_deb   <= '0;
                            end else begin
                                r_deb <= r_deb + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                        end
                    endcase
                end
            end

            assign buttonLevel[gi] = r_level;
            assign pressPulse[gi]  = r_press;
            assign longPulse[gi]   = r_long;
        end
    endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: vector table plus long-press,
// dropout, reset-mid-hold and simultaneous-press sequences.
`timescale 1ns/1ps
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] raw = 3'b000;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] lng;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(.DEBOUNCE_TICKS(3), .LONG_PRESS_TICKS(200)) dut (
        .clockSignal (clk),
        .resetSignal (rst),
        .buttonRaw   (raw),
        .buttonLevel (level),
        .pressPulse  (press),
        .longPulse   (lng)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] lng;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then observe 1 ns after the rising edge.
    task automatic tick(input logic [2:0] r, input logic rs);
        @(negedge clk);
        raw = r;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    int  press_n, long_n, press_at, long_at, press2_at;
    bit  consec, lvl_drop;
    logic prev_p, prev_l;

    initial begin
        // bit0: clean press cycles 0..9; bit1: bounce 1,0,1,0 then held 4..15
        tbl[0]  = '{3'b011, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{3'b011, 3'b000, 3'b000, 3'b000};
        tbl[3]  = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[4]  = '{3'b011, 3'b001, 3'b001, 3'b000};
        tbl[5]  = '{3'b011, 3'b001, 3'b000, 3'b000};
        tbl[6]  = '{3'b011, 3'b001, 3'b000, 3'b000};
        tbl[7]  = '{3'b011, 3'b001, 3'b000, 3'b000};
        tbl[8]  = '{3'b011, 3'b011, 3'b010, 3'b000};
        tbl[9]  = '{3'b011, 3'b011, 3'b000, 3'b000};
        tbl[10] = '{3'b010, 3'b011, 3'b000, 3'b000};
        tbl[11] = '{3'b010, 3'b011, 3'b000, 3'b000};
        tbl[12] = '{3'b010, 3'b011, 3'b000, 3'b000};
        tbl[13] = '{3'b010, 3'b011, 3'b000, 3'b000};
        tbl[14] = '{3'b010, 3'b010, 3'b000, 3'b000};
        tbl[15] = '{3'b010, 3'b010, 3'b000, 3'b000};
        tbl[16] = '{3'b000, 3'b010, 3'b000, 3'b000};
        tbl[17] = '{3'b000, 3'b010, 3'b000, 3'b000};
        tbl[18] = '{3'b000, 3'b010, 3'b000, 3'b000};
        tbl[19] = '{3'b000, 3'b010, 3'b000, 3'b000};
        tbl[20] = '{3'b000, 3'b000, 3'b000, 3'b000};
        tbl[21] = '{3'b000, 3'b000, 3'b000, 3'b000};

        // Reset: asynchronous, outputs zero before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_async_level", 32'(level), 32'd0);
        chk("reset_async_press", 32'(press), 32'd0);
        chk("reset_async_long",  32'(lng),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_clk_outputs", 32'({level, press, lng}), 32'd0);
        tick(3'b000, 1'b0);

        // Table: clean press on bit0, bounced press on bit1
        for (int v = 0; v < 22; v++) begin
            tick(tbl[v].raw, 1'b0);
            chk($sformatf("vec%0d_level", v), 32'(level), 32'(tbl[v].lvl));
            chk($sformatf("vec%0d_press", v), 32'(press), 32'(tbl[v].prs));
            chk($sformatf("vec%0d_long",  v), 32'(lng),   32'(tbl[v].lng));
        end
        repeat (6) tick(3'b000, 1'b0);

        // Long press on bit2, held 250 cycles
        press_n = 0; long_n = 0; press_at = -1; long_at = -1;
        consec = 0; prev_p = 0; prev_l = 0;
        for (int c = 0; c < 280; c++) begin
            tick({(c < 250), 2'b00}, 1'b0);
            if (press[2]) begin press_n++; press_at = c; end
            if (lng[2])   begin long_n++;  long_at  = c; end
            if ((press[2] && prev_p) || (lng[2] && prev_l)) consec = 1;
            prev_p = press[2];
            prev_l = lng[2];
            if (c == 253) chk("long_level_before_release", 32'(level[2]), 32'd1);
            if (c == 254) chk("long_level_after_release",  32'(level[2]), 32'd0);
        end
        chk("long_press_count", 32'(press_n),  32'd1);
        chk("long_press_cycle", 32'(press_at), 32'd4);
        chk("long_long_count",  32'(long_n),   32'd1);
        chk("long_long_cycle",  32'(long_at),  32'd204);
        chk("long_no_consec",   32'(consec),   32'd0);
        repeat (6) tick(3'b000, 1'b0);

        // Two-cycle dropout on bit0 at hold cycle 100
        press_n = 0; long_n = 0; long_at = -1; lvl_drop = 0;
        for (int c = 0; c < 270; c++) begin
            tick({2'b00, ((c < 260) && (c != 104) && (c != 105))}, 1'b0);
            if (press[0]) press_n++;
            if (lng[0])   begin long_n++; long_at = c; end
            if (c >= 4 && c <= 263 && level[0] !== 1'b1) lvl_drop = 1;
        end
        chk("glitch_press_count", 32'(press_n),  32'd1);
        chk("glitch_long_count",  32'(long_n),   32'd1);
        chk("glitch_long_cycle",  32'(long_at),  32'd204);
        chk("glitch_level_held",  32'(lvl_drop), 32'd0);
        repeat (6) tick(3'b000, 1'b0);

        // Reset pulsed at hold cycle 150 with bit0 still held
        press_n = 0; long_n = 0; press2_at = -1;
        for (int c = 0; c < 280; c++) begin
            tick(3'b001, (c == 155) || (c == 156));
            if (press[0]) begin press_n++; press2_at = c; end
            if (lng[0])   long_n++;
            if (c == 154) begin
                chk("rst_mid_level_before", 32'(level[0]), 32'd1);
                rst = 1'b1;
                #1;
                chk("rst_mid_async_outputs", 32'({level, press, lng}), 32'd0);
            end
            if (c == 155 || c == 156)
                chk($sformatf("rst_mid_outputs_c%0d", c), 32'({level, press, lng}), 32'd0);
        end
        chk("rst_mid_press_count", 32'(press_n),   32'd2);
        chk("rst_mid_fresh_press", 32'(press2_at), 32'd161);
        chk("rst_mid_no_long",     32'(long_n),    32'd0);
        repeat (6) tick(3'b000, 1'b0);

        // Bits 0 and 1 rise together
        press_n = 0;
        for (int c = 0; c < 30; c++) begin
            tick((c < 20) ? 3'b011 : 3'b000, 1'b0);
            if (press != 3'b000) press_n++;
            if (c == 4) chk("simul_press_vector", 32'(press), 32'h3);
        end
        chk("simul_pulse_cycles", 32'(press_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
